// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed big-endian byte stream and writes it into processor RAM, then releases the CPU.
// Latency: a word is written the cycle after its fourth byte; RUN follows the halt-word (or last-word) write by one cycle.
// Backpressure: byte_ready drops outside HDR0/HDR1/DATA/CHK and during every wEn cycle; optional checksum byte under LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W    = 9,
  parameter int MAX_WORDS = 512
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              wEn,
  output logic [31:0]       wDat,
  output logic              working,
  output logic              done,
  output logic              err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, HDR0 = 3'd1, HDR1 = 3'd2, DATA = 3'd3,
    TERM = 3'd4, CHK  = 3'd5, RUN  = 3'd6, ERR  = 3'd7
  } state_t;
  // After the final RAM write the trailing checksum byte is still owed.
  localparam state_t POST_LOAD = CHK;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, HDR0 = 3'd1, HDR1 = 3'd2, DATA = 3'd3,
    TERM = 3'd4, RUN  = 3'd6, ERR  = 3'd7
  } state_t;
  localparam state_t POST_LOAD = RUN;
`endif

  // Length limit widened by one bit so header values up to 65535 compare cleanly.
  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  state_t              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [15:0]         widx_q, widx_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [31:0]         asm_q, asm_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdat_q, wdat_d;
  logic                done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif
  logic                accept;

  // Ready only in byte-consuming states, and never while a RAM write is in flight.
  always_comb begin
    byte_ready = 1'b0;
    case (state_q)
      HDR0, HDR1, DATA: byte_ready = !wen_q;
`ifdef LOADER_CHECKSUM_EN
      CHK:              byte_ready = !wen_q;
`endif
      default:          byte_ready = 1'b0;
    endcase
  end

  assign accept  = byte_valid && byte_ready;
  assign addr    = addr_q;
  assign wEn     = wen_q;
  assign wDat    = wdat_q;
  assign working = (state_q == RUN);
  assign done    = done_q;
  assign err     = (state_q == ERR);

  // Next-state and write-port logic; abort overrides everything at the end.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    wen_d   = 1'b0;
    addr_d  = '0;
    wdat_d  = '0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    if (accept) csum_d = csum_q ^ byte_data;
`endif

    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d = HDR0;
          count_d = '0;
          widx_d  = '0;
          bcnt_d  = '0;
          asm_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      HDR0: begin
        if (accept) begin
          count_d = {byte_data, count_q[7:0]};
          state_d = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          count_d = {count_q[15:8], byte_data};
          if ({1'b0, count_d} > MAXW)  state_d = ERR;
          else if (count_d == 16'd0)   state_d = TERM;
          else                         state_d = DATA;
        end
      end
      DATA: begin
        if (wen_q) begin
          // Write cycle: advance the word index and leave once the last word is out.
          widx_d = widx_q + 16'd1;
          if (widx_q + 16'd1 == count_q) begin
            state_d = ({1'b0, count_q} < MAXW) ? TERM : POST_LOAD;
          end
        end else if (accept) begin
          asm_d  = {asm_q[23:0], byte_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wen_d  = 1'b1;
            addr_d = ADDR_W'(widx_q);
            wdat_d = {asm_q[23:0], byte_data};
          end
        end
      end
      TERM: begin
        // First cycle issues the halt-word write, second cycle moves on.
        if (wen_q) begin
          state_d = POST_LOAD;
        end else begin
          wen_d  = 1'b1;
          addr_d = ADDR_W'(count_q);
          wdat_d = 32'h0;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) state_d = (byte_data == csum_q) ? RUN : ERR;
      end
`endif
      RUN: begin
        state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      wen_d   = 1'b0;
      addr_d  = '0;
      wdat_d  = '0;
    end

    done_d = (state_d == RUN) && (state_q != RUN);
  end

  // State, counters and registered write port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      widx_q  <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: drives length-prefixed programs and compares RAM writes against a list model.
// Latency: results are compared once working or err rises (bounded wait).
// Backpressure: byte_valid is toggled randomly; bytes are held until byte_ready accepts them.
module tb_prog_loader;
  localparam int ADDR_W    = 9;
  localparam int MAX_WORDS = 512;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic [ADDR_W-1:0] addr;
  logic              wEn;
  logic [31:0]       wDat;
  logic              working;
  logic              done;
  logic              err;

  int tests = 0;
  int fails = 0;

  logic [47:0] got_q[$];
  logic [47:0] exp_q[$];
  int          done_cnt = 0;
  int          viol_cnt = 0;
  logic [31:0] words [0:MAX_WORDS-1];
  logic [7:0]  ck_acc;

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .addr(addr), .wEn(wEn), .wDat(wDat), .working(working), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Record every RAM write and flag writes that overlap byte_ready or working.
  always @(negedge clock) begin
    if (wEn) begin
      got_q.push_back({16'(addr), wDat});
      if (byte_ready || working) viol_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int budget;
    bit acc;
    budget = 200;
    acc = 1'b0;
    while (!acc && budget > 0) begin
      @(negedge clock);
      byte_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      byte_data  = byte_valid ? b : 8'($urandom);
      acc = byte_valid && byte_ready;
      budget--;
    end
    ck_acc = ck_acc ^ b;
    if (!acc) begin
      tests++;
      fails++;
      $error("FAIL send_timeout observed=0 expected=1");
    end
  endtask

  task automatic do_abort();
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
  endtask

  // Reference: words 0..cnt-1 in order, then a halt word at cnt when room remains.
  task automatic build_expected(input int cnt);
    exp_q.delete();
    if (cnt <= MAX_WORDS) begin
      for (int i = 0; i < cnt; i++) exp_q.push_back({16'(i), words[i]});
      if (cnt < MAX_WORDS) exp_q.push_back({16'(cnt), 32'h0});
    end
  endtask

  task automatic run_load(input string tag, input int cnt, input bit rnd, input bit bad_ck);
    int  budget;
    bit  ok;
    logic [15:0] c16;
    c16 = 16'(cnt);
    got_q.delete();
    done_cnt = 0;
    viol_cnt = 0;
    ck_acc = 8'h00;
    build_expected(cnt);
    ok = (cnt <= MAX_WORDS) && !bad_ck;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    send_byte(c16[15:8], rnd);
    send_byte(c16[7:0], rnd);
    if (cnt <= MAX_WORDS) begin
      for (int i = 0; i < cnt; i++) begin
        logic [31:0] w;
        w = words[i];
        send_byte(w[31:24], rnd);
        send_byte(w[23:16], rnd);
        send_byte(w[15:8], rnd);
        send_byte(w[7:0], rnd);
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(bad_ck ? ~ck_acc : ck_acc, rnd);
`endif
    end
    @(negedge clock);
    byte_valid = 1'b0;
    budget = 100;
    while (!(working || err) && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    repeat (3) @(negedge clock);
    chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (i < 4 || i >= exp_q.size() - 2 || rnd)
        chk({tag, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
    end
    chk({tag, "_working"}, 64'(working), 64'(ok));
    chk({tag, "_err"}, 64'(err), 64'(!ok));
    chk({tag, "_done_cnt"}, 64'(done_cnt), ok ? 64'd1 : 64'd0);
    chk({tag, "_wen_overlap"}, 64'(viol_cnt), 64'd0);
    if (ok) begin
      chk({tag, "_run_addr"}, 64'(addr), 64'd0);
      chk({tag, "_run_wdat"}, 64'(wDat), 64'd0);
      chk({tag, "_run_wen"}, 64'(wEn), 64'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(byte_ready), 64'd0);
    chk({tag, "_addr"}, 64'(addr), 64'd0);
    chk({tag, "_wen"}, 64'(wEn), 64'd0);
    chk({tag, "_wdat"}, 64'(wDat), 64'd0);
    chk({tag, "_working"}, 64'(working), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_ready", 64'(byte_ready), 64'd0);

    // Directed program: two words plus halt word
    words[0] = 32'h10030005;
    words[1] = 32'h20001234;
    run_load("basic", 2, 1'b0, 1'b0);

    // Abort in RUN: working holds until the edge, then drops
    @(negedge clock);
    abort = 1'b1;
    #1;
    chk("abort_before_edge", 64'(working), 64'd1);
    @(posedge clock);
    #1;
    chk("abort_after_edge", 64'(working), 64'd0);
    @(negedge clock);
    abort = 1'b0;

    // Empty program: only the halt word at 0
    run_load("empty", 0, 1'b0, 1'b0);
    do_abort();

    // Oversize header 513: ERR, no writes
    run_load("oversize", 513, 1'b0, 1'b0);

    // Restart straight out of ERR with random programs and random valid toggling
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) words[i] = $urandom;
      run_load("random", n, 1'b1, 1'b0);
      do_abort();
    end

    // Full-size program: last write at 511, no halt word
    for (int i = 0; i < MAX_WORDS; i++) words[i] = $urandom;
    run_load("max", MAX_WORDS, 1'b0, 1'b0);
    do_abort();

    // Reset mid-DATA: outputs clear immediately, then a fresh load works
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    ck_acc = 8'h00;
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0);
    @(negedge clock);
    byte_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    run_load("after_reset", 3, 1'b1, 1'b0);
    do_abort();

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum byte: ERR, never working
    for (int i = 0; i < 2; i++) words[i] = $urandom;
    run_load("bad_csum", 2, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
